// File: rtl/l1_cache_nway.sv
// rtl/l1_cache_nway.sv - N-way set-associative write-back, write-allocate L1 cache with tree PLRU
module l1_cache_nway #(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         arb_mem_read,
  output logic         arb_mem_write,
  output logic [15:0]  arb_mem_address,
  output logic [127:0] arb_mem_wdata,
  input  logic [127:0] arb_mem_rdata,
  input  logic         arb_mem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int WB = $clog2(WAYS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 12 - IB;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t state_q, state_d;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  logic [WAYS-1:1] plru_q  [SETS];
  logic [WAYS-1:1] plru_d  [SETS];
  logic [WB-1:0]   victim_q, victim_d;
  logic            arb_read_q, arb_read_d;
  logic            arb_write_q, arb_write_d;
  logic [15:0]     hit_cnt_q, hit_cnt_d;
  logic [15:0]     miss_cnt_q, miss_cnt_d;

  logic [TB-1:0]   tag_mem  [SETS][WAYS];
  logic [127:0]    data_mem [SETS][WAYS];

  logic [IB-1:0]   idx;
  logic [TB-1:0]   req_tag;
  logic [2:0]      word_sel;
  logic            addr_unused;
  logic            hit;
  logic [WB-1:0]   hit_way;
  logic            has_invalid;
  logic [WB-1:0]   inv_way;
  logic [WB-1:0]   plru_way;
  logic [WB-1:0]   victim;
  logic [127:0]    hit_line;
  logic [127:0]    merged_line;
  logic            data_we;
  logic            tag_we;
  logic [WB-1:0]   we_way;
  logic [127:0]    we_line;

  assign idx         = mem_address[4 +: IB];
  assign req_tag     = mem_address[15 -: TB];
  assign word_sel    = mem_address[3:1];
  assign addr_unused = mem_address[0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_mem[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // Scan downward so the lowest-numbered invalid way wins.
  always_comb begin
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = WB'(w);
      end
    end
  end

  // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 means the LRU side is the right child.
  always_comb begin
    logic [WB-1:0] node;
    logic          b;
    node     = WB'(1);
    plru_way = '0;
    for (int l = 0; l < WB; l++) begin
      b        = plru_q[idx][node];
      plru_way = (plru_way << 1) | WB'(b);
      node     = (node << 1) | WB'(b);
    end
  end

  assign victim = has_invalid ? inv_way : plru_way;

  assign hit_line  = data_mem[idx][hit_way];
  assign mem_rdata = hit_line[{word_sel, 4'h0} +: 16];

  always_comb begin
    merged_line = hit_line;
    if (mem_byte_enable[0]) merged_line[{word_sel, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{word_sel, 4'h8} +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    logic [WB-1:0] node;
    logic [WB-1:0] path;
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    plru_d      = plru_q;
    victim_d    = victim_q;
    arb_read_d  = arb_read_q;
    arb_write_d = arb_write_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_resp    = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    we_way      = hit_way;
    we_line     = merged_line;
    node        = WB'(1);
    path        = hit_way;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp  = 1'b1;
            hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            for (int l = 0; l < WB; l++) begin
              plru_d[idx][node] = ~path[WB-1];
              node              = (node << 1) | WB'(path[WB-1]);
              path              = path << 1;
            end
            if (mem_write) begin
              dirty_d[idx][hit_way] = 1'b1;
              data_we               = 1'b1;
            end
          end else begin
            miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            victim_d   = victim;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              state_d     = S_WRITEBACK;
              arb_write_d = 1'b1;
            end else begin
              state_d    = S_ALLOCATE;
              arb_read_d = 1'b1;
            end
          end
        end
      end
      S_WRITEBACK: begin
        if (arb_mem_resp) begin
          state_d     = S_ALLOCATE;
          arb_write_d = 1'b0;
          arb_read_d  = 1'b1;
        end
      end
      S_ALLOCATE: begin
        if (arb_mem_resp) begin
          state_d                = S_IDLE;
          arb_read_d             = 1'b0;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          data_we                = 1'b1;
          tag_we                 = 1'b1;
          we_way                 = victim_q;
          we_line                = arb_mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '{default: '0};
      dirty_q     <= '{default: '0};
      plru_q      <= '{default: '0};
      victim_q    <= '0;
      arb_read_q  <= 1'b0;
      arb_write_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      plru_q      <= plru_d;
      victim_q    <= victim_d;
      arb_read_q  <= arb_read_d;
      arb_write_q <= arb_write_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[idx][we_way] <= we_line;
    if (tag_we)  tag_mem[idx][we_way]  <= req_tag;
  end

  assign arb_mem_read    = arb_read_q;
  assign arb_mem_write   = arb_write_q;
  assign arb_mem_address = (state_q == S_WRITEBACK) ? {tag_mem[idx][victim_q], idx, 4'h0}
                                                    : {req_tag, idx, 4'h0};
  assign arb_mem_wdata   = data_mem[idx][victim_q];
  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;

endmodule

// File: doc/l1_cache_nway.md
# l1_cache_nway

Parametrised N-way set-associative, write-back, write-allocate L1 cache for the LC-3b pipeline. It generalises the fixed 2-way L1 to configurable associativity and set count, using tree pseudo-LRU replacement and saturating hit/miss counters. It sits between a CPU port (instruction or data) and the memory arbiter, exchanging 128-bit lines (`lc3b_cache_line`) with the arbiter.

## Interface
- `WAYS`, 2: associativity; power of two, 2..8.
- `SETS`, 8: set count; power of two, 2..64.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mem_read`, `mem_write`  in  1 each  CPU request; held stable until `mem_resp`.
- `mem_byte_enable`  in  2  write byte mask (`lc3b_mem_wmask`).
- `mem_address`  in  16  byte address (`lc3b_word`).
- `mem_wdata`  in  16  write data.
- `mem_resp`  out  1  request complete; one-cycle pulse.
- `mem_rdata`  out  16  selected word; valid while `mem_resp`=1.
- `arb_mem_read`, `arb_mem_write`  out  1 each  arbiter line request; held until `arb_mem_resp`.
- `arb_mem_address`  out  16  line address; bits [3:0]=0.
- `arb_mem_wdata`  out  128  victim line for writeback.
- `arb_mem_rdata`  in  128  fill line.
- `arb_mem_resp`  in  1  arbiter completion; single-cycle pulse.
- `hit_count`, `miss_count`  out  16 each  saturating performance counters.

## Operation
- Address split: offset [3:0] (bits [3:1] select the word, bit 0 is ignored), index = next log2(SETS) bits, tag = remaining upper bits.
- Per-way state per set: valid, dirty, tag, 128-bit data. Per set: WAYS-1 tree-PLRU bits.
- Both `mem_read` and `mem_write` high: the request is treated as a write.
- FSM states:
  - IDLE: compare the request against all ways.
    - Hit: assert `mem_resp`. A read returns the selected word. A write merges the enabled bytes into the word and sets dirty. PLRU is updated so it points away from the hit way.
    - Miss: choose a victim. The victim is the lowest-numbered invalid way; if none is invalid, it is the PLRU way. Go to WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - WRITEBACK: `arb_mem_write`=1, `arb_mem_address`={victim tag, index, 4'b0}, `arb_mem_wdata`=victim line. On `arb_mem_resp`, go to ALLOCATE.
  - ALLOCATE: `arb_mem_read`=1, `arb_mem_address`={request tag, index, 4'b0}. On `arb_mem_resp`, load `arb_mem_rdata` into the victim way, set valid=1, dirty=0, write the tag, then return to IDLE. In IDLE the request now hits.
- PLRU is updated only on hits. A filled line becomes MRU on its subsequent hit.
- `miss_count` increments once per request that misses in IDLE. `hit_count` increments on each `mem_resp`, so a missed request also counts one hit on completion. Both saturate at 0xFFFF.
- `arb_mem_resp` is ignored in IDLE.

## Timing
- Hit latency: `mem_resp` is combinational in the same cycle the request is presented in IDLE.
- Clean miss: 1 IDLE cycle, then ALLOCATE (arbiter latency), then `mem_resp` in the IDLE cycle following fill.
- Dirty miss: adds a WRITEBACK phase before ALLOCATE.
- `arb_mem_read` and `arb_mem_write` are never high together. Both drop in the cycle after `arb_mem_resp`.
- Reset values:
  - FSM returns to IDLE.
  - All valid, dirty and PLRU bits cleared.
  - Counters set to 0.
  - `mem_resp`, `arb_mem_read`, `arb_mem_write` = 0.
  - Tag and data arrays are not reset.
- Reset mid-miss: the arbiter request is dropped immediately (asynchronous). A partial fill is discarded and the line stays invalid.
- Request deasserted mid-miss: not permitted; behaviour is undefined.

## Test plan
Configuration for all scenarios: WAYS=4, SETS=8 (index [6:4], tag [15:7]).
- Cold read miss: after reset, read 0x0012.
  - Expect `arb_mem_read`=1 with address 0x0010.
  - Return a line whose word1=0xBEEF.
  - Next IDLE cycle: `mem_resp`=1, `mem_rdata`=0xBEEF.
  - Counters: `miss_count`=1, `hit_count`=1.
- Hit write and read: write 0x0012, data 0xA5A5, be=01.
  - `mem_resp` in the same cycle.
  - A following read of 0x0012 returns 0xBEA5 with no arbiter activity.
- PLRU eviction: fill set 0 via reads of 0x0000, 0x0080, 0x0100, 0x0180 (ways 0..3, each hit once).
  - Then read 0x0200: victim is way 0, and the next read of 0x0000 misses.
- Dirty writeback: write 0x0004, data 0x1234, be=11. Then miss to the same set with all ways valid and way 0 as PLRU.
  - Expect `arb_mem_write` with address 0x0000, word2=0x1234.
  - Then `arb_mem_read` for the new line.
- Async reset during ALLOCATE:
  - `arb_mem_read` falls without a clock edge.
  - After release, the original address misses again and the counters read 0.
- Counter saturation: force `hit_count` to 0xFFFF via hits; one more hit keeps it at 0xFFFF.
